// File: rtl/mem_pkg.sv
// Shared defaults and read/write encodings for the dual-port memory.
package mem_pkg;

  localparam int unsigned DATA_W_DEFAULT = 4;
  localparam int unsigned ADDR_W_DEFAULT = 3;
  localparam int unsigned DEPTH_DEFAULT  = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage : mem_pkg

// File: rtl/mem_read_port.sv
// Registered read port: captures the addressed word on read cycles
// and holds its last value during write cycles.
module mem_read_port
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              rw,
  input  logic [DATA_W-1:0] rdData,
  output logic [DATA_W-1:0] dataOut
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dataOut <= '0;
    end else if (rw == RW_READ) begin
      dataOut <= rdData;
    end
  end

endmodule : mem_read_port

// File: rtl/mem_sintetizado.sv
// True dual-port memory with read-first behaviour and port A winning
// same-address write collisions.
module mem_sintetizado
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic              rwA,
  input  logic              rwB,
  input  logic [DATA_W-1:0] DataInA,
  input  logic [DATA_W-1:0] DataInB,
  output logic [DATA_W-1:0] DataOutA,
  output logic [DATA_W-1:0] DataOutB
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wrA_c;
  logic              wrB_c;

  // Port B's write is dropped when port A writes the same word.
  always_comb begin
    wrA_c = (rwA == RW_WRITE);
    wrB_c = (rwB == RW_WRITE) && !(wrA_c && (AddrA == AddrB));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mem <= '{default: '0};
    end else begin
      if (wrA_c) mem[AddrA] <= DataInA;
      if (wrB_c) mem[AddrB] <= DataInB;
    end
  end

  // Reads sample the array before this edge's writes land (read-first).
  mem_read_port #(.DATA_W(DATA_W)) uReadA (
    .clk    (clk),
    .reset_L(reset_L),
    .rw     (rwA),
    .rdData (mem[AddrA]),
    .dataOut(DataOutA)
  );

  mem_read_port #(.DATA_W(DATA_W)) uReadB (
    .clk    (clk),
    .reset_L(reset_L),
    .rw     (rwB),
    .rdData (mem[AddrB]),
    .dataOut(DataOutB)
  );

endmodule : mem_sintetizado

// File: tb/tb_mem_sintetizado.sv
// Directed self-checking bench for mem_sintetizado.
module tb_mem_sintetizado;

  logic       clk;
  logic       reset_L;
  logic [2:0] AddrA;
  logic [2:0] AddrB;
  logic       rwA;
  logic       rwB;
  logic [3:0] DataInA;
  logic [3:0] DataInB;
  logic [3:0] DataOutA;
  logic [3:0] DataOutB;

  int nAsserts = 0;
  int nFails   = 0;

  mem_sintetizado #(.DATA_W(4), .ADDR_W(3), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .AddrA   (AddrA),
    .AddrB   (AddrB),
    .rwA     (rwA),
    .rwB     (rwB),
    .DataInA (DataInA),
    .DataInB (DataInB),
    .DataOutA(DataOutA),
    .DataOutB(DataOutB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of port stimulus, then sample just after the edge.
  task automatic step(input logic [2:0] aAddr, input logic aRw, input logic [3:0] aData,
                      input logic [2:0] bAddr, input logic bRw, input logic [3:0] bData);
    AddrA   = aAddr;
    rwA     = aRw;
    DataInA = aData;
    AddrB   = bAddr;
    rwB     = bRw;
    DataInB = bData;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    AddrA = '0; AddrB = '0; rwA = 1'b0; rwB = 1'b0; DataInA = '0; DataInB = '0;

    // Power-on reset for two cycles, with a write attempted that must be ignored.
    rwA = 1'b1; AddrA = 3'd0; DataInA = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outA", DataOutA, 4'h0);
    check("reset_outB", DataOutB, 4'h0);
    rwA = 1'b0;
    reset_L = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0, 4'h0, 3'd0, 1'b0, 4'h0);
      check($sformatf("reset_rdA%0d", i), DataOutA, 4'h0);
    end

    // Independent writes on both ports, then cross reads.
    step(3'd3, 1'b1, 4'hA, 3'd6, 1'b1, 4'h5);
    step(3'd6, 1'b0, 4'h0, 3'd3, 1'b0, 4'h0);
    check("indep_outA", DataOutA, 4'h5);
    check("indep_outB", DataOutB, 4'hA);

    // Same-address write collision: A wins.
    step(3'd2, 1'b1, 4'h1, 3'd2, 1'b1, 4'h2);
    check("coll_holdA", DataOutA, 4'h5);
    check("coll_holdB", DataOutB, 4'hA);
    step(3'd2, 1'b0, 4'h0, 3'd2, 1'b0, 4'h0);
    check("coll_outB", DataOutB, 4'h1);
    check("coll_outA", DataOutA, 4'h1);

    // Read-during-write on the other port returns old data.
    step(3'd4, 1'b1, 4'h7, 3'd0, 1'b0, 4'h0);
    check("rdw_holdA", DataOutA, 4'h1);
    step(3'd4, 1'b1, 4'hC, 3'd4, 1'b0, 4'h0);
    check("rdw_oldB", DataOutB, 4'h7);
    step(3'd0, 1'b0, 4'h0, 3'd4, 1'b0, 4'h0);
    check("rdw_newB", DataOutB, 4'hC);

    // B writes while A reads the same word.
    step(3'd7, 1'b0, 4'h0, 3'd7, 1'b1, 4'hE);
    check("rdwB_oldA", DataOutA, 4'h0);
    check("rdwB_holdB", DataOutB, 4'hC);
    step(3'd7, 1'b0, 4'h0, 3'd7, 1'b0, 4'h0);
    check("same_rdA", DataOutA, 4'hE);
    check("same_rdB", DataOutB, 4'hE);

    // Port A holds its output through its own write cycle.
    step(3'd5, 1'b1, 4'h9, 3'd0, 1'b0, 4'h0);
    step(3'd5, 1'b0, 4'h0, 3'd0, 1'b0, 4'h0);
    check("hold_rdA", DataOutA, 4'h9);
    step(3'd5, 1'b1, 4'h3, 3'd5, 1'b0, 4'h0);
    check("hold_wrA", DataOutA, 4'h9);
    check("hold_rdB_old", DataOutB, 4'h9);
    step(3'd5, 1'b0, 4'h0, 3'd0, 1'b0, 4'h0);
    check("hold_newA", DataOutA, 4'h3);

    // Asynchronous mid-run reset with writes pending on both ports.
    AddrA = 3'd1; rwA = 1'b1; DataInA = 4'hF;
    AddrB = 3'd6; rwB = 1'b1; DataInB = 4'hD;
    #2;
    reset_L = 1'b0;
    #1;
    check("async_outA", DataOutA, 4'h0);
    check("async_outB", DataOutB, 4'h0);
    @(posedge clk);
    #1;
    check("inrst_outA", DataOutA, 4'h0);
    check("inrst_outB", DataOutB, 4'h0);
    #2;
    reset_L = 1'b1;
    rwA = 1'b0; rwB = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0, 4'h0, 3'(7 - i), 1'b0, 4'h0);
      check($sformatf("post_rdA%0d", i), DataOutA, 4'h0);
      check($sformatf("post_rdB%0d", 7 - i), DataOutB, 4'h0);
    end

    // Normal operation resumes after reset.
    step(3'd1, 1'b1, 4'h6, 3'd0, 1'b0, 4'h0);
    step(3'd0, 1'b0, 4'h0, 3'd1, 1'b0, 4'h0);
    check("resume_rdB", DataOutB, 4'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule : tb_mem_sintetizado
